// File: rtl/add18_pkg.sv
// Shared definitions for the 18-bit burst adder arbiter.
//   WORD_W   : operand word width handled by the adder core
//   BLK_W    : carry-skip block size inside the adder core
//   ID_MAX_W : widest requester id the result record can carry (up to 8 requesters)
//   state_t  : arbiter FSM states
//   result_t : one result word as held in the output stage
package add18_pkg;

    localparam int WORD_W   = 18;
    localparam int BLK_W    = 3;
    localparam int NBLK     = WORD_W / BLK_W;
    localparam int ID_MAX_W = 3;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    typedef struct packed {
        logic [WORD_W-1:0]   sum;
        logic                cout;
        logic [ID_MAX_W-1:0] id;
        logic                last;
    } result_t;

endpackage

// File: rtl/skip_add18_cin.sv
// Combinational 18-bit fixed-block carry-skip adder with explicit carry-in.
// Six 3-bit ripple blocks; a block whose bits all propagate forwards its
// carry-in directly to the next block instead of waiting on its ripple chain.
// Ports:
//   a, b   : 18-bit operands
//   cin    : carry into bit 0
//   result : {carry out, 18-bit sum}
module skip_add18_cin
    import add18_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W:0]   result
);

    genvar gi;
    generate
        for (gi = 0; gi < NBLK; gi++) begin : g_blk
            logic             blk_cin;
            logic             blk_cout;
            logic             blk_prop;
            logic [BLK_W:0]   ripple;

            if (gi == 0) begin : g_first
                assign blk_cin = cin;
            end else begin : g_chain
                assign blk_cin = g_blk[gi-1].blk_cout;
            end

            assign ripple = {1'b0, a[gi*BLK_W +: BLK_W]}
                          + {1'b0, b[gi*BLK_W +: BLK_W]}
                          + {{BLK_W{1'b0}}, blk_cin};

            // All bits propagate: the carry out equals the carry in, so skip.
            assign blk_prop = &(a[gi*BLK_W +: BLK_W] ^ b[gi*BLK_W +: BLK_W]);
            assign blk_cout = blk_prop ? blk_cin : ripple[BLK_W];

            assign result[gi*BLK_W +: BLK_W] = ripple[BLK_W-1:0];
        end
    endgenerate

    assign result[WORD_W] = g_blk[NBLK-1].blk_cout;

endmodule

// File: rtl/add18_burst_arbiter.sv
// Round-robin arbiter sharing one 18-bit adder among NREQ requesters.
// A grant is locked for a whole burst and the carry is chained between the
// words of that burst, so an N-word burst is one (N*18)-bit addition.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester word handshake
//   req_a, req_b          : per-requester operands, requester i at [i*W +: W]
//   req_last              : word is the final word of its burst
//   res_valid/res_ready   : registered result handshake
//   res_sum, res_cout     : sum word and its carry out
//   res_id, res_last      : owning requester, last word of burst
//   busy                  : a multi-word burst is in progress
module add18_burst_arbiter
    import add18_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = WORD_W,
    parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_last,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_sum,
    output logic              res_cout,
    output logic [ID_W-1:0]   res_id,
    output logic              res_last,
    output logic              busy
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NREQ - 1);

    state_t          state_reg;
    logic [ID_W-1:0] rr_ptr_reg;
    logic [ID_W-1:0] gnt_reg;
    logic            carry_reg;
    logic            res_valid_reg;
    result_t         res_reg;

    logic            slot_free;
    logic            pick_found;
    logic [ID_W-1:0] pick_idx;
    logic [NREQ-1:0] ready_vec;
    logic [ID_W-1:0] sel;
    logic            sel_cin;
    logic [W-1:0]    sel_a;
    logic [W-1:0]    sel_b;
    logic            sel_last;
    logic            accept;
    logic [W:0]      add_result;
    result_t         res_next;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == LAST_ID) ? '0 : id + ID_W'(1);
    endfunction

    // Round-robin pick: first valid requester at or after ptr, wrapping.
    // Returns {found, index}.
    function automatic logic [ID_W:0] pick(input logic [NREQ-1:0] v,
                                           input logic [ID_W-1:0] ptr);
        logic            found;
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] win;
        found = 1'b0;
        win   = '0;
        idx   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && v[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = next_id(idx);
        end
        return {found, win};
    endfunction

    always_comb begin
        slot_free              = !res_valid_reg || res_ready;
        {pick_found, pick_idx} = pick(req_valid, rr_ptr_reg);
        ready_vec              = '0;
        sel                    = gnt_reg;
        sel_cin                = carry_reg;
        if (state_reg == S_IDLE) begin
            // A fresh burst always starts with carry-in 0.
            sel     = pick_idx;
            sel_cin = 1'b0;
            if (pick_found && slot_free) begin
                ready_vec[pick_idx] = 1'b1;
            end
        end else begin
            // Locked: only the granted requester can be served, even if it stalls.
            if (req_valid[gnt_reg] && slot_free) begin
                ready_vec[gnt_reg] = 1'b1;
            end
        end
        accept   = |(ready_vec & req_valid);
        sel_a    = req_a[int'(sel)*W +: W];
        sel_b    = req_b[int'(sel)*W +: W];
        sel_last = req_last[sel];
    end

    skip_add18_cin u_adder (
        .a      (sel_a),
        .b      (sel_b),
        .cin    (sel_cin),
        .result (add_result)
    );

    always_comb begin
        res_next      = '0;
        res_next.sum  = add_result[W-1:0];
        res_next.cout = add_result[W];
        res_next.id   = ID_MAX_W'(sel);
        res_next.last = sel_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            rr_ptr_reg    <= '0;
            gnt_reg       <= '0;
            carry_reg     <= 1'b0;
            res_valid_reg <= 1'b0;
            res_reg       <= '0;
        end else begin
            if (accept) begin
                res_valid_reg <= 1'b1;
                res_reg       <= res_next;
                carry_reg     <= sel_last ? 1'b0 : add_result[W];
                if (sel_last) begin
                    state_reg  <= S_IDLE;
                    rr_ptr_reg <= next_id(sel);
                end else if (state_reg == S_IDLE) begin
                    state_reg <= S_BURST;
                    gnt_reg   <= sel;
                end
            end else if (res_ready) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    // Id bits above ID_W are always zero; fold them into a sink.
    logic unused_id_bits;
    assign unused_id_bits = ^res_reg.id;

    assign req_ready = ready_vec;
    assign res_valid = res_valid_reg;
    assign res_sum   = res_reg.sum;
    assign res_cout  = res_reg.cout;
    assign res_id    = res_reg.id[ID_W-1:0];
    assign res_last  = res_reg.last;
    assign busy      = (state_reg == S_BURST);

endmodule

// File: tb/tb_add18_burst_arbiter.sv
module tb_add18_burst_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 18;
    localparam int ID_W = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_last;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_sum;
    logic              res_cout;
    logic [ID_W-1:0]   res_id;
    logic              res_last;
    logic              busy;

    int errors = 0;
    int checks = 0;

    add18_burst_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_last  (req_last),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id),
        .res_last  (res_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         last;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_last  = '0;
    endtask

    task automatic drive(input int id, input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
        req_valid[id]     = 1'b1;
        req_a[id*W +: W]  = a;
        req_b[id*W +: W]  = b;
        req_last[id]      = last;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string tag, input int id, input logic [W-1:0] sum,
                             input logic cout, input logic last);
        check({tag, ".valid"}, 32'(res_valid), 32'd1);
        check({tag, ".sum"},   32'(res_sum),   32'(sum));
        check({tag, ".cout"},  32'(res_cout),  32'(cout));
        check({tag, ".id"},    32'(res_id),    32'(id));
        check({tag, ".last"},  32'(res_last),  32'(last));
        $display("%s: id=%0d sum=0x%05h cout=%0d last=%0d", tag, res_id, res_sum, res_cout, res_last);
    endtask

    initial begin
        // id, a, b, last, expected sum, expected cout
        vecs[0] = '{0, 18'h3FFFF, 18'h00001, 1'b1, 18'h00000, 1'b1};
        vecs[1] = '{2, 18'h3FFFF, 18'h00001, 1'b0, 18'h00000, 1'b1};
        vecs[2] = '{2, 18'h00005, 18'h00000, 1'b1, 18'h00006, 1'b0};
        vecs[3] = '{1, 18'h12345, 18'h0ABCD, 1'b1, 18'h1CF12, 1'b0};
        vecs[4] = '{3, 18'h20000, 18'h20000, 1'b1, 18'h00000, 1'b1};
        vecs[5] = '{3, 18'h2AAAA, 18'h15555, 1'b1, 18'h3FFFF, 1'b0};
        vecs[6] = '{1, 18'h3FFFF, 18'h3FFFF, 1'b0, 18'h3FFFE, 1'b1};
        vecs[7] = '{1, 18'h2AAAA, 18'h15555, 1'b0, 18'h00000, 1'b1};
        vecs[8] = '{1, 18'h00000, 18'h00000, 1'b1, 18'h00001, 1'b0};
        vecs[9] = '{3, 18'h1FFFF, 18'h00001, 1'b1, 18'h20000, 1'b0};

        rst_n     = 1'b0;
        res_ready = 1'b1;
        clear_reqs();
        repeat (3) @(posedge clk);
        #1;
        check("rst.res_valid", 32'(res_valid), 32'd0);
        check("rst.busy",      32'(busy),      32'd0);
        check("rst.req_ready", 32'(req_ready), 32'd0);
        check("rst.res_sum",   32'(res_sum),   32'd0);
        check("rst.res_cout",  32'(res_cout),  32'd0);
        check("rst.res_id",    32'(res_id),    32'd0);
        check("rst.res_last",  32'(res_last),  32'd0);
        rst_n = 1'b1;
        tick();

        // Table: one requester at a time, words back to back.
        for (int i = 0; i < 10; i++) begin
            clear_reqs();
            drive(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].last);
            #1;
            check($sformatf("vec%0d.ready", i), 32'(req_ready), 32'(1 << vecs[i].id));
            tick();
            check_res($sformatf("vec%0d", i), vecs[i].id, vecs[i].exp_sum,
                      vecs[i].exp_cout, vecs[i].last);
        end
        clear_reqs();
        tick();
        check("table.drain", 32'(res_valid), 32'd0);
        check("table.busy",  32'(busy),      32'd0);

        // Round robin: all four hold single-word bursts; rr_ptr is 0 here.
        for (int i = 0; i < NREQ; i++) drive(i, 18'(32'h100 * (i + 1)), 18'h00011, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check_res($sformatf("rr%0d", k), k % NREQ,
                      18'(32'h100 * ((k % NREQ) + 1) + 32'h11), 1'b0, 1'b1);
        end
        clear_reqs();
        tick();

        // Grant lock: rr_ptr is 2, so req1 starts alone, then req3 joins.
        drive(1, 18'h3FFFF, 18'h00001, 1'b0);
        tick();
        check_res("lock.w0", 1, 18'h00000, 1'b1, 1'b0);
        check("lock.busy", 32'(busy), 32'd1);
        drive(3, 18'h00007, 18'h00008, 1'b1);
        drive(1, 18'h00001, 18'h00001, 1'b0);
        #1;
        check("lock.ready1", 32'(req_ready), 32'b0010);
        tick();
        check_res("lock.w1", 1, 18'h00003, 1'b0, 1'b0);
        req_valid[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("lock.gap%0d.valid", k), 32'(res_valid), 32'd0);
            check($sformatf("lock.gap%0d.busy", k),  32'(busy),      32'd1);
            check($sformatf("lock.gap%0d.ready", k), 32'(req_ready), 32'd0);
        end
        drive(1, 18'h00010, 18'h00020, 1'b1);
        #1;
        check("lock.ready2", 32'(req_ready), 32'b0010);
        tick();
        check_res("lock.w2", 1, 18'h00030, 1'b0, 1'b1);
        req_valid[1] = 1'b0;
        #1;
        check("lock.ready3", 32'(req_ready), 32'b1000);
        tick();
        check_res("lock.r3", 3, 18'h0000F, 1'b0, 1'b1);
        clear_reqs();
        tick();

        // Backpressure: rr_ptr is 0.
        drive(0, 18'h00001, 18'h00002, 1'b1);
        tick();
        check_res("bp.first", 0, 18'h00003, 1'b0, 1'b1);
        res_ready = 1'b0;
        drive(0, 18'h00004, 18'h00005, 1'b1);
        #1;
        check("bp.ready_hold", 32'(req_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_res($sformatf("bp.hold%0d", k), 0, 18'h00003, 1'b0, 1'b1);
            check($sformatf("bp.hold%0d.ready", k), 32'(req_ready), 32'd0);
        end
        res_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(req_ready), 32'b0001);
        tick();
        check_res("bp.second", 0, 18'h00009, 1'b0, 1'b1);
        clear_reqs();
        tick();
        check("bp.no_dup", 32'(res_valid), 32'd0);

        // Reset mid-burst: rr_ptr is 1 before reset.
        drive(1, 18'h3FFFF, 18'h00001, 1'b0);
        tick();
        check("rstmid.busy_before",  32'(busy),          32'd1);
        check("rstmid.carry_before", 32'(dut.carry_reg), 32'd1);
        rst_n = 1'b0;
        clear_reqs();
        #1;
        check("rstmid.res_valid", 32'(res_valid),     32'd0);
        check("rstmid.busy",      32'(busy),          32'd0);
        check("rstmid.carry",     32'(dut.carry_reg), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        // req1 would win if rr_ptr had survived the reset.
        drive(0, 18'h00005, 18'h00006, 1'b1);
        drive(1, 18'h00000, 18'h00000, 1'b1);
        tick();
        check_res("rstmid.fresh0", 0, 18'h0000B, 1'b0, 1'b1);
        req_valid[0] = 1'b0;
        tick();
        check_res("rstmid.next1", 1, 18'h00000, 1'b0, 1'b1);
        clear_reqs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
